// File: rtl/multicycle_mem.sv
// Main-memory model behind the cache controller: word array with a fully
// pipelined fixed-latency read return and an in-flight read counter.
module multicycle_mem #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [2:0]        outstanding
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [LATENCY-1:0]    vld_p;
  logic [DATA_W-1:0]     data_p [LATENCY];
  logic                  unused_addr_bits;

  // Word index drops the byte bit; upper bits alias.
  assign idx              = addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};
  assign rd_acc           = enable & ~wr;
  assign wr_acc           = enable & wr & rst_n;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= data_in;
    end
  end

  // Stage p0 captures the pre-write array word; later stages just shift.
  always_ff @(posedge clk) begin
    data_p[0] <= mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
    end
  end

  // Control: valid chain, return register and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p       <= '0;
      data_valid  <= 1'b0;
      data_out    <= '0;
      outstanding <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      data_valid <= vld_p[LATENCY-1];
      if (vld_p[LATENCY-1]) begin
        data_out <= data_p[LATENCY-1];
      end
      outstanding <= outstanding + {2'b00, rd_acc} - {2'b00, vld_p[LATENCY-1]};
    end
  end

endmodule

// File: tb/tb_multicycle_mem.sv
// Directed bench for multicycle_mem: per-cycle vector table plus hand-written
// reset sequences.
module tb_multicycle_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [2:0]  outstanding;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  eo;
  } vec_t;

  vec_t vecs[$];

  multicycle_mem #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("outstanding_bound", {31'd0, (outstanding > 3'd4)}, 32'd0);
    end
  end

  task automatic add(input logic en, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic ev, input logic [15:0] ed,
                     input logic [2:0] eo);
    vec_t v;
    v.en = en; v.wr = w; v.addr = a; v.din = d; v.ev = ev; v.ed = ed; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic ev, input logic [15:0] ed, input logic [2:0] eo);
    add(1'b0, 1'b0, 16'h0000, 16'h0000, ev, ed, eo);
  endtask

  task automatic drive(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rst_n = r; enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [15:0] ed,
                           input logic [2:0] eo);
    check({tag, ".valid"}, {31'd0, data_valid}, {31'd0, ev});
    check({tag, ".data"}, {16'd0, data_out}, {16'd0, ed});
    check({tag, ".outst"}, {29'd0, outstanding}, {29'd0, eo});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    // Write then read 0x0020: return 4 edges after acceptance.
    add(1, 1, 16'h0020, 16'hBEEF, 0, 16'h0000, 0);
    add(1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 1);
    idle(0, 16'h0000, 1); idle(0, 16'h0000, 1); idle(0, 16'h0000, 1);
    idle(1, 16'hBEEF, 0);
    idle(0, 16'hBEEF, 0);
    // Preload block then back-to-back fill reads.
    for (int k = 0; k < 8; k++)
      add(1, 1, 16'h0100 + 16'(2*k), 16'h1000 + 16'(k), 0, 16'hBEEF, 0);
    add(1, 0, 16'h0100, 0, 0, 16'hBEEF, 1);
    add(1, 0, 16'h0102, 0, 0, 16'hBEEF, 2);
    add(1, 0, 16'h0104, 0, 0, 16'hBEEF, 3);
    add(1, 0, 16'h0106, 0, 0, 16'hBEEF, 4);
    add(1, 0, 16'h0108, 0, 1, 16'h1000, 4);
    add(1, 0, 16'h010A, 0, 1, 16'h1001, 4);
    add(1, 0, 16'h010C, 0, 1, 16'h1002, 4);
    add(1, 0, 16'h010E, 0, 1, 16'h1003, 4);
    idle(1, 16'h1004, 3); idle(1, 16'h1005, 2); idle(1, 16'h1006, 1);
    idle(1, 16'h1007, 0); idle(0, 16'h1007, 0);
    // Read-before-write ordering on 0x0040.
    add(1, 1, 16'h0040, 16'h1111, 0, 16'h1007, 0);
    add(1, 0, 16'h0040, 16'h0000, 0, 16'h1007, 1);
    add(1, 1, 16'h0040, 16'h2222, 0, 16'h1007, 1);
    add(1, 0, 16'h0040, 16'h0000, 0, 16'h1007, 2);
    idle(0, 16'h1007, 2); idle(1, 16'h1111, 1); idle(0, 16'h1111, 1);
    idle(1, 16'h2222, 0); idle(0, 16'h2222, 0);
    // Aliasing: 0x0007 and 0x0806 share word 3.
    add(1, 1, 16'h0007, 16'hABCD, 0, 16'h2222, 0);
    add(1, 0, 16'h0806, 16'h0000, 0, 16'h2222, 1);
    idle(0, 16'h2222, 1); idle(0, 16'h2222, 1); idle(0, 16'h2222, 1);
    idle(1, 16'hABCD, 0);
    // Gapped issue: reads in cycles 0, 2, 3.
    add(1, 0, 16'h0100, 0, 0, 16'hABCD, 1);
    idle(0, 16'hABCD, 1);
    add(1, 0, 16'h0102, 0, 0, 16'hABCD, 2);
    add(1, 0, 16'h0104, 0, 0, 16'hABCD, 3);
    idle(1, 16'h1000, 2); idle(0, 16'h1000, 2); idle(1, 16'h1001, 1);
    idle(1, 16'h1002, 0); idle(0, 16'h1002, 0);
    // Byte bit ignored: 0x0011 and 0x0010 are the same word.
    add(1, 1, 16'h0011, 16'h5A5A, 0, 16'h1002, 0);
    add(1, 0, 16'h0010, 16'h0000, 0, 16'h1002, 1);
    idle(0, 16'h1002, 1); idle(0, 16'h1002, 1); idle(0, 16'h1002, 1);
    idle(1, 16'h5A5A, 0);

    // Reset state, with a read request present that must be ignored.
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    check_out("reset", 1'b0, 16'h0000, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_out("post_reset_idle", 1'b0, 16'h0000, 3'd0);

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eo);
    end

    // Reset mid-burst: in-flight reads dropped, write during reset ignored.
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
    check_out("burst0", 1'b0, 16'h5A5A, 3'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h0102, 16'h0000);
    check_out("burst1", 1'b0, 16'h5A5A, 3'd2);
    drive(1'b1, 1'b1, 1'b0, 16'h0104, 16'h0000);
    check_out("burst2", 1'b0, 16'h5A5A, 3'd3);
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'hDEAD);
    check_out("midreset", 1'b0, 16'h0000, 3'd0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check_out($sformatf("drain%0d", c), 1'b0, 16'h0000, 3'd0);
    end

    // Array survives reset; the write presented during reset had no effect.
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    check_out("keep_rd", 1'b0, 16'h0000, 3'd1);
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_out("keep_ret", 1'b1, 16'hBEEF, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
